// File: rtl/unidad_riesgos_pkg.sv
// Shared constants for the hazard/stall unit: FSM encoding, parameter defaults
// and the architectural zero register.
package unidad_riesgos_pkg;
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  localparam int WAIT_MAX_DEF = 16;
  localparam int CNT_W_DEF    = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/cont_estad.sv
// Free-running wrap-around statistics counter with count enable.
module cont_estad #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/unidad_riesgos.sv
// Hazard/stall control for the 5-stage pipeline: load-use, taken branch in MEM
// and multi-cycle data memory, plus stall/flush statistics and timeout flag.
module unidad_riesgos
  import unidad_riesgos_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_addr_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             cfe_en,
  output logic             dex_en,
  output logic             em_en,
  output logic             mw_en,
  output logic             cfe_flush,
  output logic             dex_flush,
  output logic             em_flush,
  output logic             mw_flush,
  output logic             pc_sel_branch,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int             WCW  = $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WMAX = WCW'(WAIT_MAX);

  logic [0:0]     state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           timeout_q, timeout_d;
  logic           pending, timeout_hit, mem_stall, load_use;
  logic           stall_inc, flush_inc;

  always_comb begin
    pending     = mem_access && !dmem_ready;
    // Once the wait counter has hit the limit the access is forced complete
    // and this cycle behaves as a normal (non-waiting) cycle.
    timeout_hit = pending && (state_q == ST_MEM_WAIT) && (wcnt_q == WMAX);
    mem_stall   = pending && !timeout_hit;
    load_use    = ex_mem_read && (ex_addr_rt != REG_ZERO) &&
                  ((ex_addr_rt == id_rs) || (id_uses_rt && (ex_addr_rt == id_rt)));

    state_d   = ST_RUN;
    wcnt_d    = '0;
    timeout_d = timeout_q | timeout_hit;
    if (mem_stall) begin
      state_d = ST_MEM_WAIT;
      wcnt_d  = (state_q == ST_RUN) ? WCW'(1) : wcnt_q + WCW'(1);
    end
  end

  always_comb begin
    pc_en         = 1'b1;
    cfe_en        = 1'b1;
    dex_en        = 1'b1;
    em_en         = 1'b1;
    mw_en         = 1'b1;
    cfe_flush     = 1'b0;
    dex_flush     = 1'b0;
    em_flush      = 1'b0;
    mw_flush      = 1'b0;
    pc_sel_branch = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (!rst) begin
      {pc_en, cfe_en, dex_en, em_en, mw_en} = '0;
    end else if (mem_stall) begin
      {pc_en, cfe_en, dex_en, em_en, mw_en} = '0;
      mw_flush  = 1'b1;
      stall_inc = 1'b1;
    end else if (mem_branch_taken) begin
      pc_sel_branch = 1'b1;
      cfe_flush     = 1'b1;
      dex_flush     = 1'b1;
      em_flush      = 1'b1;
      flush_inc     = 1'b1;
    end else if (load_use) begin
      pc_en     = 1'b0;
      cfe_en    = 1'b0;
      dex_flush = 1'b1;
      stall_inc = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

  cont_estad #(.W(CNT_W)) u_cnt_stall (
    .clk (clk), .rst (rst), .en (stall_inc), .cnt (stall_count)
  );

  cont_estad #(.W(CNT_W)) u_cnt_flush (
    .clk (clk), .rst (rst), .en (flush_inc), .cnt (flush_count)
  );
endmodule
